vector_packer: RTL and testbench
================================

Name: vector_packer

Overview:
Upstream feeder for the core's vector FIFO write port. It accepts a scalar sample stream (one N-bit sample per handshake), packs WIDTH_VECTOR samples into one vector and writes it through fifo_wdata/fifo_winc, honouring fifo_full. An assembly register plus a one-entry output holding register keep input acceptance running while the FIFO is full, until both are occupied. Runs in the FIFO write clock domain.

Parameters:
WIDTH_VECTOR, 16, lanes per vector; power of 2, >= 2
N, 16, bits per sample/lane
CNT_W, 16, width of the written-vector counter

Ports:
clk  in  1  write-domain clock (connects to core fifo_wclk)
rst  in  1  asynchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  packer can accept a sample this cycle
s_data  in  N  input sample
s_last  in  1  last sample of a burst; the partial vector is flushed with zero padding
fifo_full  in  1  core FIFO full flag, write side
fifo_winc  out  1  write strobe to core FIFO
fifo_wdata  out  [WIDTH_VECTOR-1:0][N-1:0]  vector to core FIFO; lane 0 holds the first sample
vec_cnt  out  CNT_W  number of vectors written, wraps modulo 2**CNT_W
padded  out  1  one-cycle pulse on a FIFO write whose vector was zero-padded

Behaviour:
- Reset (async assert, sync-safe release): lane index 0, assembly register 0, asm_full 0, out_pending 0, fifo_wdata 0, fifo_winc 0, vec_cnt 0, padded 0. s_ready is forced 0 while rst is high.
- Accept: sample is accepted when s_valid && s_ready on a clk edge. It is written into assembly lane idx, and idx increments.
- Vector complete: when the accepted sample is in lane WIDTH_VECTOR-1, or s_last=1 on any lane. Lanes above the last one are zero. idx returns to 0.
- Transfer: a completed assembly moves to the output register at the same edge if the output register is free, or is being drained this cycle (fifo_winc=1). Otherwise asm_full is set and the vector waits.
- s_ready = !rst && !asm_full.
- A waiting assembly (asm_full=1) transfers on the first edge where fifo_winc=1. asm_full clears at that edge, and s_ready returns to 1 in the next cycle.
- fifo_winc = out_pending && !fifo_full. This is combinational from the registered out_pending and the fifo_full input. fifo_wdata is driven straight from the output register.
- Latency: final sample accepted at edge t gives fifo_winc high in cycle t+1 if fifo_full=0. Sustained throughput is 1 sample/cycle with no bubbles.
- Drain: on fifo_winc=1, out_pending clears at the edge unless it is reloaded at the same edge (back-to-back transfer).
- vec_cnt increments on every fifo_winc=1 edge and wraps from 2**CNT_W-1 to 0.
- padded=1 exactly while fifo_winc=1 for a vector completed by s_last at a lane below WIDTH_VECTOR-1.
- s_last on lane WIDTH_VECTOR-1 completes a normal vector with no padding.
- s_last on lane 0 produces a vector with lanes 1..WIDTH_VECTOR-1 zero.
- fifo_full held high: at most 2 vectors are buffered (output register plus assembly), and s_ready then stays 0. No sample is ever dropped or duplicated.
- fifo_full deasserting in the same cycle the assembly completes: both the drain and the transfer happen at that edge.
- s_data/s_last are ignored when s_valid=0.
- Reset mid-vector discards the partial assembly and the pending output; no fifo_winc occurs after assertion.

Decomposition:
- Package finder_pkg:
  - LANE_W = $clog2(WIDTH_VECTOR)
  - typedef vec_t (packed [WIDTH_VECTOR-1:0][N-1:0]), shared with core
  - localparam for the zero vector
- Sub-module vector_hold_reg: one-entry output holding register with load/drain/pending/padded flag. The top level keeps the lane index, assembly register, asm_full and vec_cnt.

Test Plan:
Test parameters: WIDTH_VECTOR=4, N=8.
1. Reset, then samples 0x11,0x22,0x33,0x44 back-to-back with fifo_full=0 -> one cycle after 0x44, fifo_winc=1 for 1 cycle; fifo_wdata lanes0..3 = 11,22,33,44; vec_cnt=1; padded=0.
2. Samples 0xA1,0xA2 with s_last on 0xA2 -> fifo_wdata = A1,A2,00,00; padded=1; next vector begins at lane 0.
3. fifo_full=1; stream 12 samples continuously -> 8 accepted; s_ready=0 from the cycle after the 8th acceptance; no fifo_winc. Release fifo_full -> two consecutive fifo_winc cycles with correct vectors; s_ready=1 the cycle after the first write.
4. 64 samples streamed continuously, fifo_full=0 -> s_ready stays 1 throughout; 16 writes; vec_cnt=16; a scoreboard matches every lane in order.
5. rst pulse after 2 of 4 samples -> outputs 0 asynchronously. After release, a new 4-sample vector is written with no stale lanes.
6. CNT_W=2; write 5 vectors -> vec_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/finder_pkg.sv
// Shared definitions for the vector FIFO write-side packer.
// Holds the core's default vector geometry, the default vector type, a zero-vector
// constant and a helper that sizes lane-index counters for any lane count.
package finder_pkg;

  // Default geometry used by the core; blocks with other geometry use their own parameters.
  localparam int unsigned DEF_WIDTH_VECTOR = 16;
  localparam int unsigned DEF_N            = 16;
  localparam int unsigned LANE_W           = $clog2(DEF_WIDTH_VECTOR);

  // Default vector as seen on the core FIFO data port; lane 0 is the first sample.
  typedef logic [DEF_WIDTH_VECTOR-1:0][DEF_N-1:0] vec_t;

  localparam vec_t VEC_ZERO = '0;

  // Width of a lane index for the given lane count, never narrower than one bit.
  function automatic int unsigned lane_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vector_hold_reg.sv
// One-entry output holding register in front of the core vector FIFO.
// Ports:
//   clk, rst   - write-domain clock, asynchronous active-high reset
//   load       - capture load_data/load_pad; wins over a same-edge drain
//   load_data  - completed vector to hold
//   load_pad   - vector was flushed early by s_last and zero-padded
//   fifo_full  - core FIFO full flag
//   pending    - register holds a vector not yet written
//   winc       - FIFO write strobe (pending && !fifo_full)
//   wdata      - held vector, driven straight from the register
//   padded     - high while writing a padded vector
module vector_hold_reg
  import finder_pkg::*;
#(
  parameter int unsigned WIDTH_VECTOR = 16,
  parameter int unsigned N            = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [WIDTH_VECTOR-1:0][N-1:0]   load_data,
  input  logic                             load_pad,
  input  logic                             fifo_full,
  output logic                             pending,
  output logic                             winc,
  output logic [WIDTH_VECTOR-1:0][N-1:0]   wdata,
  output logic                             padded
);

  logic                           pending_q;
  logic                           pad_q;
  logic [WIDTH_VECTOR-1:0][N-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      pad_q     <= 1'b0;
      data_q    <= '0;
    end else if (load) begin
      // A load on a draining edge keeps the register full (back-to-back writes).
      pending_q <= 1'b1;
      pad_q     <= load_pad;
      data_q    <= load_data;
    end else if (winc) begin
      pending_q <= 1'b0;
      pad_q     <= 1'b0;
    end
  end

  assign pending = pending_q;
  assign winc    = pending_q && !fifo_full;
  assign wdata   = data_q;
  assign padded  = winc && pad_q;

endmodule

// File: rtl/vector_packer.sv
// Packs a scalar sample stream into WIDTH_VECTOR-lane vectors for the core vector FIFO.
// An assembly register fills lane by lane; a completed vector moves to a one-entry
// holding register that writes the FIFO, so input keeps flowing while the FIFO is full
// until both stages are occupied.
// Ports:
//   clk, rst              - FIFO write clock, asynchronous active-high reset
//   s_valid/s_ready       - sample handshake; s_data is the sample, s_last flushes
//   fifo_full             - core FIFO full flag
//   fifo_winc/fifo_wdata  - FIFO write strobe and vector (lane 0 = first sample)
//   vec_cnt               - vectors written, wrapping
//   padded                - pulse on writes of zero-padded vectors
module vector_packer
  import finder_pkg::*;
#(
  parameter int unsigned WIDTH_VECTOR = 16,
  parameter int unsigned N            = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N-1:0]                     s_data,
  input  logic                             s_last,
  input  logic                             fifo_full,
  output logic                             fifo_winc,
  output logic [WIDTH_VECTOR-1:0][N-1:0]   fifo_wdata,
  output logic [CNT_W-1:0]                 vec_cnt,
  output logic                             padded
);

  localparam int unsigned    IDX_W     = lane_width(WIDTH_VECTOR);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(WIDTH_VECTOR - 1);

  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [WIDTH_VECTOR-1:0][N-1:0] asm_q, asm_d;
  logic                           asm_full_q, asm_full_d;
  logic                           asm_pad_q, asm_pad_d;
  logic [CNT_W-1:0]               cnt_q;

  logic                           accept;
  logic                           lane_last;
  logic                           complete;
  logic                           hold_pending;
  logic                           hold_free;
  logic [WIDTH_VECTOR-1:0][N-1:0] asm_merged;

  logic                           load;
  logic [WIDTH_VECTOR-1:0][N-1:0] load_data;
  logic                           load_pad;

  assign s_ready   = !rst && !asm_full_q;
  assign accept    = s_valid && s_ready;
  assign lane_last = (idx_q == LAST_LANE);
  assign complete  = accept && (lane_last || s_last);
  // The holding register can take a vector when empty or when it is written this cycle.
  assign hold_free = !hold_pending || fifo_winc;

  // Assembly register with the incoming sample dropped into the current lane.
  // Lanes above idx are already zero because the register is cleared on each completion.
  always_comb begin
    asm_merged        = asm_q;
    asm_merged[idx_q] = s_data;
  end

  always_comb begin
    idx_d      = idx_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    asm_pad_d  = asm_pad_q;
    load       = 1'b0;
    load_data  = asm_merged;
    load_pad   = 1'b0;

    if (asm_full_q) begin
      // A parked vector can only move once the holding register is being written.
      if (fifo_winc) begin
        load       = 1'b1;
        load_data  = asm_q;
        load_pad   = asm_pad_q;
        asm_d      = '0;
        asm_full_d = 1'b0;
        asm_pad_d  = 1'b0;
      end
    end else if (accept) begin
      if (complete) begin
        idx_d = '0;
        if (hold_free) begin
          load      = 1'b1;
          load_data = asm_merged;
          load_pad  = !lane_last;
          asm_d     = '0;
        end else begin
          asm_d      = asm_merged;
          asm_full_d = 1'b1;
          asm_pad_d  = !lane_last;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
        asm_d = asm_merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      asm_pad_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      asm_pad_q  <= asm_pad_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (fifo_winc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign vec_cnt = cnt_q;

  vector_hold_reg #(
    .WIDTH_VECTOR (WIDTH_VECTOR),
    .N            (N)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_pad  (load_pad),
    .fifo_full (fifo_full),
    .pending   (hold_pending),
    .winc      (fifo_winc),
    .wdata     (fifo_wdata),
    .padded    (padded)
  );

endmodule

// File: tb/tb_vector_packer.sv
module tb_vector_packer;

  localparam int unsigned WV = 4;
  localparam int unsigned NB = 8;
  localparam int unsigned CW = 16;

  typedef logic [WV-1:0][NB-1:0] tvec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [NB-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          fifo_full = 1'b0;

  logic          s_ready, fifo_winc, padded;
  tvec_t         fifo_wdata;
  logic [CW-1:0] vec_cnt;

  logic          s_ready2, fifo_winc2, padded2;
  tvec_t         fifo_wdata2;
  logic [1:0]    vec_cnt2;

  int            checks = 0;
  int            errors = 0;
  tvec_t         exp_q[$];
  logic          exp_pad_q[$];
  int unsigned   wr_count = 0;
  tvec_t         mon_v;
  logic          mon_p;

  always #5 clk = ~clk;

  vector_packer #(.WIDTH_VECTOR(WV), .N(NB), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_full  (fifo_full),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .vec_cnt    (vec_cnt),
    .padded     (padded)
  );

  // Narrow-counter instance fed the same stream, used for the wrap test.
  vector_packer #(.WIDTH_VECTOR(WV), .N(NB), .CNT_W(2)) u_dut_cnt2 (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready2),
    .s_data     (s_data),
    .s_last     (s_last),
    .fifo_full  (fifo_full),
    .fifo_winc  (fifo_winc2),
    .fifo_wdata (fifo_wdata2),
    .vec_cnt    (vec_cnt2),
    .padded     (padded2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every FIFO write is matched against the next hand-built expected vector.
  always @(negedge clk) begin
    if (!rst && fifo_winc) begin
      if (exp_q.size() == 0) begin
        check("write_expected", 64'(fifo_winc), 64'd0);
      end else begin
        mon_v = exp_q.pop_front();
        mon_p = exp_pad_q.pop_front();
        check("wdata", 64'(fifo_wdata), 64'(mon_v));
        check("padded", 64'(padded), 64'(mon_p));
        check("vec_cnt_at_write", 64'(vec_cnt), 64'(wr_count[CW-1:0]));
      end
      wr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input tvec_t v, input logic p);
    exp_q.push_back(v);
    exp_pad_q.push_back(p);
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [NB-1:0] d, input logic last);
    logic r;
    int   n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      r = s_ready;
      tick();
      n++;
    end while (!r && n < 50);
    if (!r) check("send_timeout", 64'(s_ready), 64'd1);
    s_last = 1'b0;
  endtask

  task automatic stop();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send4(input logic [NB-1:0] b, input logic last_on_3);
    send(b, 1'b0);
    send(b + 8'd1, 1'b0);
    send(b + 8'd2, 1'b0);
    send(b + 8'd3, last_on_3);
    stop();
  endtask

  initial begin
    int    acc;
    int    cyc;
    int    stalls;
    logic  r;
    tvec_t v;
    logic [1:0] cnt2_seq [4];

    // Reset state
    tick();
    tick();
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_winc", 64'(fifo_winc), 64'd0);
    check("rst_wdata", 64'(fifo_wdata), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("rst_padded", 64'(padded), 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(s_ready), 64'd1);

    // 1: full vector, one-cycle latency
    expect_vec(32'h44332211, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    stop();
    check("t1_winc", 64'(fifo_winc), 64'd1);
    check("t1_wdata", 64'(fifo_wdata), 64'h44332211);
    check("t1_padded", 64'(padded), 64'd0);
    tick();
    check("t1_winc_once", 64'(fifo_winc), 64'd0);
    check("t1_vec_cnt", 64'(vec_cnt), 64'd1);

    // 2: s_last on lane 1, then s_last on lane 0
    expect_vec(32'h0000A2A1, 1'b1);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    stop();
    check("t2_winc", 64'(fifo_winc), 64'd1);
    check("t2_wdata", 64'(fifo_wdata), 64'h0000A2A1);
    check("t2_padded", 64'(padded), 64'd1);
    tick();
    check("t2_padded_pulse", 64'(padded), 64'd0);
    expect_vec(32'h000000B1, 1'b1);
    send(8'hB1, 1'b1);
    stop();
    check("t2_lane0_wdata", 64'(fifo_wdata), 64'h000000B1);
    check("t2_lane0_padded", 64'(padded), 64'd1);
    tick();

    // 3: FIFO full, two vectors buffered, then back-to-back drain
    fifo_full = 1'b1;
    expect_vec(32'h04030201, 1'b0);
    expect_vec(32'h08070605, 1'b0);
    acc     = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_data = 8'(acc + 1);
      r      = s_ready;
      tick();
      if (r) acc++;
    end
    stop();
    check("t3_accepted", 64'(acc), 64'd8);
    check("t3_ready_low", 64'(s_ready), 64'd0);
    check("t3_no_write", 64'(wr_count), 64'd3);
    fifo_full = 1'b0;
    #1;
    check("t3_winc1", 64'(fifo_winc), 64'd1);
    check("t3_ready_still_low", 64'(s_ready), 64'd0);
    tick();
    check("t3_winc2", 64'(fifo_winc), 64'd1);
    check("t3_ready_back", 64'(s_ready), 64'd1);
    tick();
    check("t3_winc_done", 64'(fifo_winc), 64'd0);
    check("t3_vec_cnt", 64'(vec_cnt), 64'd5);

    // 4: 64 samples streamed with no bubbles after a fresh reset
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    wr_count = 0;
    tick();
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) v[j] = 8'(8'h40 + 4 * k + j);
      expect_vec(v, 1'b0);
    end
    acc     = 0;
    cyc     = 0;
    stalls  = 0;
    s_valid = 1'b1;
    while (acc < 64 && cyc < 200) begin
      s_data = 8'(8'h40 + acc);
      r      = s_ready;
      if (!r) stalls++;
      tick();
      cyc++;
      if (r) acc++;
    end
    stop();
    check("t4_accepted", 64'(acc), 64'd64);
    check("t4_stalls", 64'(stalls), 64'd0);
    check("t4_cycles", 64'(cyc), 64'd64);
    tick();
    tick();
    check("t4_vec_cnt", 64'(vec_cnt), 64'd16);
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // 5: reset mid-vector with a pending output
    fifo_full = 1'b1;
    send4(8'hC1, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    stop();
    check("t5_held_wdata", 64'(fifo_wdata), 64'hC4C3C2C1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_wdata", 64'(fifo_wdata), 64'd0);
    check("t5_rst_winc", 64'(fifo_winc), 64'd0);
    check("t5_rst_ready", 64'(s_ready), 64'd0);
    check("t5_rst_vec_cnt", 64'(vec_cnt), 64'd0);
    fifo_full = 1'b0;
    tick();
    check("t5_rst_no_write", 64'(fifo_winc), 64'd0);
    rst      = 1'b0;
    wr_count = 0;
    tick();
    expect_vec(32'hAA998877, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    send(8'h99, 1'b0);
    send(8'hAA, 1'b0);
    stop();
    check("t5_winc", 64'(fifo_winc), 64'd1);
    check("t5_wdata", 64'(fifo_wdata), 64'hAA998877);
    tick();
    check("t6_cnt2_0", 64'(vec_cnt2), 64'd1);

    // 6: 2-bit counter wrap; final vector ends with s_last on the top lane (no padding)
    cnt2_seq[0] = 2'd2;
    cnt2_seq[1] = 2'd3;
    cnt2_seq[2] = 2'd0;
    cnt2_seq[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) v[j] = 8'(16 * k + j + 1);
      expect_vec(v, 1'b0);
      send4(8'(16 * k + 1), (k == 3));
      tick();
      tick();
      check("t6_cnt2", 64'(vec_cnt2), 64'(cnt2_seq[k]));
    end
    check("t6_vec_cnt", 64'(vec_cnt), 64'd5);
    tick();
    check("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
